// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync/blank decode, line/frame strobes, frame counter and pipeline-matched sync copies
//
// Ports:
//   vga_clk      in   pixel clock; all logic runs on its posedge
//   reset_n      in   synchronous active-low reset
//   pix_en       in   advance the raster one pixel on this edge
//   DrawX/DrawY  out  current raster position
//   blank        out  1 = visible pixel
//   hs/vs        out  active-low syncs decoded from the presented position
//   hs_d/vs_d    out  hs/vs delayed PIPE_DELAY clocks
//   blank_d      out  blank delayed PIPE_DELAY clocks
//   line_start   out  one-cycle pulse when DrawX becomes 0
//   frame_start  out  one-cycle pulse when (0,0) is presented
//   frame_count  out  frame number, wraps 255->0
module vga_timing_gen #(
   parameter int H_ACT      = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACT      = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 1
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       pix_en,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       hs_d,
   output logic       vs_d,
   output logic       blank_d,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);
   localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
   // 11-bit decode constants so a 1024 boundary does not wrap to 0
   localparam logic [10:0] HA  = 11'(H_ACT);
   localparam logic [10:0] HS0 = 11'(H_ACT + H_FP);
   localparam logic [10:0] HS1 = 11'(H_ACT + H_FP + H_SYNC);
   localparam logic [10:0] VA  = 11'(V_ACT);
   localparam logic [10:0] VS0 = 11'(V_ACT + V_FP);
   localparam logic [10:0] VS1 = 11'(V_ACT + V_FP + V_SYNC);
   localparam logic [9:0]  HL  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  VL  = 10'(V_TOTAL - 1);

   if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_params
      $error("vga_timing_gen: totals must be <= 1024 and PIPE_DELAY in 0..4");
   end

   typedef enum logic {PRIME, RUN} state_t;

   state_t      r_state;
   logic [9:0]  r_x, r_y;
   logic [7:0]  r_fc;
   logic        r_blank, r_hs, r_vs, r_ls, r_fs;
   logic        w_eol, w_eof;
   logic [9:0]  w_nx, w_ny;
   logic [10:0] w_nx11, w_ny11;

   // Outputs are decoded from the position about to be loaded, so they are registered alongside it
   assign w_eol  = r_x == HL;
   assign w_eof  = w_eol && r_y == VL;
   assign w_nx   = (r_state == PRIME || w_eol) ? '0 : r_x + 10'd1;
   assign w_ny   = (r_state == PRIME || w_eof) ? '0 : w_eol ? r_y + 10'd1 : r_y;
   assign w_nx11 = {1'b0, w_nx};
   assign w_ny11 = {1'b0, w_ny};

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         r_state <= PRIME;
         r_x     <= '0;
         r_y     <= '0;
         r_blank <= 1'b0;
         r_hs    <= 1'b1;
         r_vs    <= 1'b1;
         r_ls    <= 1'b0;
         r_fs    <= 1'b0;
         r_fc    <= '0;
      end else if (pix_en) begin
         r_state <= RUN;
         r_x     <= w_nx;
         r_y     <= w_ny;
         r_blank <= w_nx11 < HA && w_ny11 < VA;
         r_hs    <= !(w_nx11 >= HS0 && w_nx11 < HS1);
         r_vs    <= !(w_ny11 >= VS0 && w_ny11 < VS1);
         r_ls    <= w_nx == '0;
         r_fs    <= w_nx == '0 && w_ny == '0;
         r_fc    <= r_fc + {7'd0, r_state == RUN && w_eof};
      end else begin
         r_ls    <= 1'b0;
         r_fs    <= 1'b0;
      end
   end

   assign DrawX       = r_x;
   assign DrawY       = r_y;
   assign blank       = r_blank;
   assign hs          = r_hs;
   assign vs          = r_vs;
   assign line_start  = r_ls;
   assign frame_start = r_fs;
   assign frame_count = r_fc;

   // Delay line runs every clock so it tracks the renderers' registered RGB regardless of pix_en
   if (PIPE_DELAY == 0) begin : g_nodly
      assign hs_d    = r_hs;
      assign vs_d    = r_vs;
      assign blank_d = r_blank;
   end else begin : g_dly
      logic [2:0] r_pipe [PIPE_DELAY];
      always_ff @(posedge vga_clk) begin
         if (!reset_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= 3'b110;
         end else begin
            r_pipe[0] <= {r_hs, r_vs, r_blank};
            for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
         end
      end
      assign {hs_d, vs_d, blank_d} = r_pipe[PIPE_DELAY-1];
   end
endmodule
